sprite_anim_ctrl: RTL

//  Parametrised sprite animation/motion controller for the pixel pipeline. Divides

---
 rtl/sprite_anim_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/sprite_anim_ctrl.sv
// Sprite animation/motion controller: tick prescaler, frame sequencer and bouncing X motion.
// Build option SPRITE_PINGPONG_EN: frames run up then back down instead of wrapping.
//
// state      | meaning
// MOVE_RIGHT | sprite steps +X on walking ticks until it reaches the right bound
// MOVE_LEFT  | sprite steps -X on walking ticks until it reaches the left bound
module sprite_anim_ctrl #(
  parameter int FRAMES   = 4,
  parameter int TICK_DIV = 5000000,
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int SPRITE_W = 64,
  parameter int X_INIT   = 256,
  parameter int Y_POS    = 300,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 639,
  parameter int STEP     = 8,
  localparam int FW      = $clog2(FRAMES)
) (
  input  logic           pixel_clk,
  input  logic           reset,
  input  logic           anim_en,
  input  logic           walk_en,
  output logic           tick,
  output logic [FW-1:0]  frame_idx,
  output logic           dir,
  output logic [X_W-1:0] pos_x1,
  output logic [X_W-1:0] pos_x2,
  output logic [Y_W-1:0] pos_y
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TICK_DIV - 1);
  localparam logic [FW-1:0]    FRAME_LAST = FW'(FRAMES - 1);

  // Bound checks use one extra bit so x1 + STEP + SPRITE_W cannot wrap.
  localparam logic [X_W:0] STEP_X = (X_W + 1)'(STEP);
  localparam logic [X_W:0] SPAN_X = (X_W + 1)'(SPRITE_W);
  localparam logic [X_W:0] MIN_X  = (X_W + 1)'(X_MIN);
  localparam logic [X_W:0] MAX_X  = (X_W + 1)'(X_MAX);

  localparam logic [X_W-1:0] STEP_N   = X_W'(STEP);
  localparam logic [X_W-1:0] SPAN_N   = X_W'(SPRITE_W);
  localparam logic [X_W-1:0] X1_RIGHT = X_W'(X_MAX - SPRITE_W);
  localparam logic [X_W-1:0] X1_LEFT  = X_W'(X_MIN);
  localparam logic [X_W-1:0] X1_RST   = X_W'(X_INIT);
  localparam logic [X_W-1:0] X2_RST   = X_W'(X_INIT + SPRITE_W);

  typedef enum logic {
    MOVE_RIGHT = 1'b0,
    MOVE_LEFT  = 1'b1
  } move_t;

  move_t           move_q, move_d;
  logic [CNT_W-1:0] pres_q;
  logic [FW-1:0]    frame_d;
  logic [X_W-1:0]   x1_d;
  logic [X_W:0]     x1_ext;

`ifdef SPRITE_PINGPONG_EN
  logic down_q, down_d;
`endif

  assign x1_ext = {1'b0, pos_x1};
  assign dir    = (move_q == MOVE_LEFT);
  assign pos_y  = Y_W'(Y_POS);

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      pres_q <= '0;
      tick   <= 1'b0;
    end else begin
      tick   <= (pres_q == CNT_LAST);
      pres_q <= (pres_q == CNT_LAST) ? '0 : pres_q + CNT_W'(1);
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      move_q    <= MOVE_RIGHT;
      frame_idx <= '0;
      pos_x1    <= X1_RST;
      pos_x2    <= X2_RST;
    end else begin
      move_q    <= move_d;
      frame_idx <= frame_d;
      pos_x1    <= x1_d;
      pos_x2    <= x1_d + SPAN_N;
    end
  end

`ifdef SPRITE_PINGPONG_EN
  always_ff @(posedge pixel_clk) begin
    if (reset) down_q <= 1'b0;
    else       down_q <= down_d;
  end
`endif

  always_comb begin
    move_d = move_q;
    x1_d   = pos_x1;
    if (tick && walk_en) begin
      case (move_q)
        MOVE_RIGHT: begin
          if (x1_ext + STEP_X + SPAN_X > MAX_X) begin
            x1_d   = X1_RIGHT;
            move_d = MOVE_LEFT;
          end else begin
            x1_d = pos_x1 + STEP_N;
          end
        end
        MOVE_LEFT: begin
          if (x1_ext < MIN_X + STEP_X) begin
            x1_d   = X1_LEFT;
            move_d = MOVE_RIGHT;
          end else begin
            x1_d = pos_x1 - STEP_N;
          end
        end
        default: begin
          x1_d   = pos_x1;
          move_d = MOVE_RIGHT;
        end
      endcase
    end
  end

  always_comb begin
    frame_d = frame_idx;
`ifdef SPRITE_PINGPONG_EN
    down_d  = down_q;
`endif
    if (!anim_en) begin
      frame_d = '0;
`ifdef SPRITE_PINGPONG_EN
      down_d  = 1'b0;
`endif
    end else if (tick) begin
`ifdef SPRITE_PINGPONG_EN
      if (!down_q) begin
        if (frame_idx == FRAME_LAST) begin
          frame_d = frame_idx - FW'(1);
          down_d  = 1'b1;
        end else begin
          frame_d = frame_idx + FW'(1);
        end
      end else begin
        if (frame_idx == '0) begin
          frame_d = FW'(1);
          down_d  = 1'b0;
        end else begin
          frame_d = frame_idx - FW'(1);
        end
      end
`else
      frame_d = (frame_idx == FRAME_LAST) ? '0 : frame_idx + FW'(1);
`endif
    end
  end

endmodule
